exibidor_sequencia: RTL and testbench



---
 rtl/pj_pkg.sv | 34 +++
 rtl/exibidor_sequencia_if.sv | 27 ++
 rtl/contador_m.sv | 32 +++
 rtl/exibidor_sequencia.sv | 93 +++++++++
 tb/tb_exibidor_sequencia.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pj_pkg.sv
// Shared definitions for the sequence display block: state encoding,
// word geometry and the permutation check used when a word is captured.
package pj_pkg;

    localparam int N_ITENS = 4;
    localparam int IDX_W   = 2;
    localparam int WORD_W  = N_ITENS * IDX_W;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        MOSTRA  = 3'd2,
        PAUSA   = 3'd3,
        FIM     = 3'd4
    } estado_t;

    // Image index stored in slot k of a permutation word.
    function automatic logic [IDX_W-1:0] campo(input logic [WORD_W-1:0] w, input int k);
        return w[k*IDX_W +: IDX_W];
    endfunction

    // True when every slot holds a different index.
    function automatic bit perm_valida(input logic [WORD_W-1:0] w);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < N_ITENS; i++) begin
            for (int j = i + 1; j < N_ITENS; j++) begin
                if (campo(w, i) == campo(w, j)) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/exibidor_sequencia_if.sv
// Control and display bundle between the game FSM/datapath and the
// sequence display block.
interface exibidor_sequencia_if;
    import pj_pkg::*;

    logic                 iniciar;
    logic                 abortar;
    logic [WORD_W-1:0]    indices;
    logic [N_ITENS-1:0]   leds;
    logic [IDX_W-1:0]     img_atual;
    logic [IDX_W-1:0]     posicao;
    logic                 ativo;
    logic                 fim;
    logic                 erro;
    logic [2:0]           db_estado;

    modport master (
        output iniciar, abortar, indices,
        input  leds, img_atual, posicao, ativo, fim, erro, db_estado
    );

    modport slave (
        input  iniciar, abortar, indices,
        output leds, img_atual, posicao, ativo, fim, erro, db_estado
    );

endinterface

// File: rtl/contador_m.sv
// Saturating modulo-M up counter with asynchronous and synchronous clears.
// It holds at M-1 instead of wrapping so an idle phase can never alias a
// fresh one.
module contador_m #(
    parameter int M = 16,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         zera_as_i,
    input  logic         zera_s_i,
    input  logic         conta_i,
    output logic [N-1:0] valor_o
);

    localparam logic [N-1:0] TOPO = N'(M - 1);

    logic [N-1:0] cnt_q;

    // Count up while enabled, stopping at the top value.
    always_ff @(posedge clock or posedge zera_as_i) begin
        if (zera_as_i) begin
            cnt_q <= '0;
        end else if (zera_s_i) begin
            cnt_q <= '0;
        end else if (conta_i && (cnt_q != TOPO)) begin
            cnt_q <= cnt_q + N'(1);
        end
    end

    assign valor_o = cnt_q;

endmodule

// File: rtl/exibidor_sequencia.sv
// Sequence display: captures a permutation word on start, validates it,
// then shows the four images one-hot on the LEDs with a blank gap after
// each, and pulses fim at the end (with erro for an invalid word).
module exibidor_sequencia
    import pj_pkg::*;
#(
    parameter int TEMPO_IMG   = 5000,
    parameter int TEMPO_PAUSA = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    exibidor_sequencia_if.slave  bus
);

    localparam int TEMPO_MAX = (TEMPO_IMG > TEMPO_PAUSA) ? TEMPO_IMG : TEMPO_PAUSA;
    localparam int TMR_W     = (TEMPO_MAX > 1) ? $clog2(TEMPO_MAX) : 1;
    localparam logic [TMR_W-1:0] ULT_IMG   = TMR_W'(TEMPO_IMG - 1);
    localparam logic [TMR_W-1:0] ULT_PAUSA = TMR_W'(TEMPO_PAUSA - 1);
    localparam logic [IDX_W-1:0] ULT_POS   = IDX_W'(N_ITENS - 1);

    estado_t           estado_q, estado_d;
    logic [WORD_W-1:0] reg_idx_q;
    logic [IDX_W-1:0]  pos_q;
    logic              erro_q;
    logic [TMR_W-1:0]  tempo;
    logic              troca;
    logic [IDX_W-1:0]  img_sel;

    // Phase timer: restarts from zero on every state change.
    contador_m #(
        .M (TEMPO_MAX),
        .N (TMR_W)
    ) u_timer (
        .clock     (clock),
        .zera_as_i (reset),
        .zera_s_i  (troca),
        .conta_i   (1'b1),
        .valor_o   (tempo)
    );

    // Next-state selection; abort overrides everything outside OCIOSO.
    always_comb begin
        // NOTE: default assignment first, so no path leaves estado_d unassigned (no latch).
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:  if (bus.iniciar && !bus.abortar) estado_d = CARREGA;
            CARREGA: estado_d = perm_valida(reg_idx_q) ? MOSTRA : FIM;
            MOSTRA:  if (tempo == ULT_IMG) estado_d = PAUSA;
            PAUSA:   if (tempo == ULT_PAUSA) estado_d = (pos_q == ULT_POS) ? FIM : MOSTRA;
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
        if ((estado_q inside {CARREGA, MOSTRA, PAUSA}) && bus.abortar) estado_d = OCIOSO;
    end

    assign troca = (estado_d != estado_q);

    // State register plus captured word, slot counter and error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            reg_idx_q <= '0;
            pos_q     <= '0;
            erro_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            estado_q <= estado_d;
            case (estado_q)
                OCIOSO: begin
                    if (estado_d == CARREGA) begin
                        reg_idx_q <= bus.indices;
                        pos_q     <= '0;
                        erro_q    <= 1'b0;
                    end
                end
                CARREGA: if (estado_d == FIM) erro_q <= 1'b1;
                PAUSA:   if (estado_d == MOSTRA) pos_q <= pos_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only.
    assign img_sel       = campo(reg_idx_q, int'(pos_q));
    assign bus.leds      = (estado_q == MOSTRA) ? (N_ITENS'(1) << img_sel) : '0;
    assign bus.img_atual = (estado_q == MOSTRA) ? img_sel : '0;
    assign bus.posicao   = (estado_q == OCIOSO) ? '0 : pos_q;
    assign bus.ativo     = (estado_q == CARREGA) || (estado_q == MOSTRA) || (estado_q == PAUSA);
    assign bus.fim       = (estado_q == FIM);
    assign bus.erro      = erro_q;
    assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Self-checking bench for exibidor_sequencia with short display times.
// Expected outputs per cycle come from the timing formulas and are queued
// as stimulus is applied, then compared mid-cycle.
module tb_exibidor_sequencia;
    import pj_pkg::*;

    localparam int T = 3;
    localparam int P = 2;
    localparam int C_FIM = 2 + 4 * (T + P);

    typedef struct packed {
        logic [3:0] leds;
        logic [1:0] img;
        logic [1:0] pos;
        logic       ativo;
        logic       fim;
        logic       erro;
        logic [2:0] st;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic erro_ant = 1'b0;
    obs_t exp_q[$];

    always #5 clock = ~clock;

    exibidor_sequencia_if bus ();

    exibidor_sequencia #(
        .TEMPO_IMG   (T),
        .TEMPO_PAUSA (P)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t observa();
        obs_t o;
        o.leds  = bus.leds;
        o.img   = bus.img_atual;
        o.pos   = bus.posicao;
        o.ativo = bus.ativo;
        o.fim   = bus.fim;
        o.erro  = bus.erro;
        o.st    = bus.db_estado;
        return o;
    endfunction

    // Expected outputs in cycle c of a run started with word w at cycle 0.
    function automatic obs_t modelo(input logic [7:0] w, input int c, input int abort_c,
                                    input logic e_ant);
        obs_t       o;
        logic [3:0] mapa;
        logic       valida, erro_fim;
        int         u, k;
        o    = '0;
        mapa = '0;
        for (int i = 0; i < 4; i++) mapa[w[2*i +: 2]] = 1'b1;
        valida   = (mapa == 4'hF);
        erro_fim = !valida && !(abort_c >= 0 && abort_c < 2);
        if (c == 0) begin
            o.erro = e_ant;
            return o;
        end
        o.erro = (c >= 2) && erro_fim;
        if (abort_c >= 0 && c > abort_c) return o;
        if (c == 1) begin
            o.st    = 3'd1;
            o.ativo = 1'b1;
            return o;
        end
        if (!valida) begin
            if (c == 2) begin
                o.st  = 3'd4;
                o.fim = 1'b1;
            end
            return o;
        end
        if (c < C_FIM) begin
            u       = c - 2;
            k       = u / (T + P);
            o.pos   = 2'(k);
            o.ativo = 1'b1;
            if ((u % (T + P)) < T) begin
                o.st   = 3'd2;
                o.img  = w[2*k +: 2];
                o.leds = 4'b0001 << o.img;
            end else begin
                o.st = 3'd3;
            end
        end else if (c == C_FIM) begin
            o.st  = 3'd4;
            o.fim = 1'b1;
            o.pos = 2'd3;
        end
        return o;
    endfunction

    // One run: start with w at cycle 0, optional abort and spurious start.
    task automatic run_seq(input logic [7:0] w, input int abort_c, input int spur_c,
                           input int last_c);
        obs_t e;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clock);
            #1;
            bus.iniciar = (c == 0) || (c == spur_c);
            bus.abortar = (c == abort_c);
            bus.indices = (c == 0) ? w : ((c == spur_c) ? 8'hE4 : ~w);
            exp_q.push_back(modelo(w, c, abort_c, erro_ant));
            @(negedge clock);
            e = exp_q.pop_front();
            check($sformatf("w%02h_c%0d", w, c), 32'(observa()), 32'(e));
        end
        e = modelo(w, last_c, abort_c, erro_ant);
        erro_ant    = e.erro;
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;
        bus.indices = 8'h00;

        // Reset state, checked while reset is held.
        #1 reset = 1'b1;
        #2 check("reset_async", 32'(observa()), 32'(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_release", 32'(observa()), 32'(0));

        run_seq(8'h1B, -1, -1, C_FIM + 3);   // valid, slots 3,2,1,0
        run_seq(8'hE4, -1, -1, C_FIM + 2);   // identity
        run_seq(8'h00, -1, -1, 5);           // invalid: erro stays set

        // iniciar and abortar together in OCIOSO: must stay idle.
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            bus.iniciar = (c == 0);
            bus.abortar = (c == 0);
            bus.indices = 8'h1B;
            e      = '0;
            e.erro = erro_ant;
            exp_q.push_back(e);
            @(negedge clock);
            e = exp_q.pop_front();
            check($sformatf("ini_abo_c%0d", c), 32'(observa()), 32'(e));
        end
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;

        run_seq(8'hE4, -1, -1, C_FIM + 1);   // erro clears in CARREGA
        run_seq(8'h1B, -1, 10, C_FIM + 2);   // spurious iniciar ignored
        run_seq(8'h1B, 8, -1, C_FIM + 4);    // abort at cycle 8

        // Reset asserted mid-cycle 13 must clear outputs before the next edge.
        run_seq(8'h1B, -1, -1, 13);
        #1 reset = 1'b1;
        #1 check("reset_mid_run", 32'(observa()), 32'(0));
        @(posedge clock);
        #1 reset = 1'b0;
        erro_ant = 1'b0;
        @(negedge clock);
        check("reset_mid_after", 32'(observa()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
